// File: rtl/lsu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_bus_ctrl
//   Load/store bus-request controller that sits between the LSU lane shifter
//   and the BIU. It accepts one memory op at a time from the pipeline, checks
//   size legality and alignment, builds the 8-byte lane select, and runs the
//   BIU address/ack handshake. Load data is returned unshifted; the LSU does
//   all shifting and sign extension.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   req_*             pipeline op: valid/ready, write, byte address,
//                     one-hot size (1/2/4/8 bytes), lane-shifted store data
//   resp_*            one-cycle completion pulse with raw load data and
//                     error / misalign flags (flags hold until next response)
//   bus_valid/ready   BIU address phase handshake
//   bus_write/addr/   registered op attributes, 8-byte aligned address,
//   bsel/wdata        byte lane enables and store data
//   bus_ack/rdata/err BIU completion, load data and error (sampled on ack)
// -----------------------------------------------------------------------------
module lsu_bus_ctrl #(
    parameter int PADDR_W     = 56,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [PADDR_W-1:0] req_addr,
    input  logic [3:0]         req_size,
    input  logic [63:0]        req_wdata,
    output logic               resp_valid,
    output logic [63:0]        resp_rdata,
    output logic               resp_err,
    output logic               resp_misalign,
    output logic               bus_valid,
    input  logic               bus_ready,
    output logic               bus_write,
    output logic [PADDR_W-1:0] bus_addr,
    output logic [7:0]         bus_bsel,
    output logic [63:0]        bus_wdata,
    input  logic               bus_ack,
    input  logic [63:0]        bus_rdata,
    input  logic               bus_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TMR_W-1:0]   timer;
    logic               size_legal;
    logic               misalign;
    logic               timeout;
    logic [7:0]         bsel_base;

    // Request decode, evaluated against the live request in S_IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        bsel_base  = 8'h00;
        size_legal = (req_size != 4'b0000) && ((req_size & (req_size - 4'd1)) == 4'b0000);
        misalign   = (req_size[1] &   req_addr[0])
                   | (req_size[2] & (|req_addr[1:0]))
                   | (req_size[3] & (|req_addr[2:0]));
        case (req_size)
            4'b0001: bsel_base = 8'h01;
            4'b0010: bsel_base = 8'h03;
            4'b0100: bsel_base = 8'h0F;
            4'b1000: bsel_base = 8'hFF;
            default: bsel_base = 8'h00;
        endcase
    end

    assign timeout = (timer == TMR_W'(TIMEOUT_CYC - 1));

    // Handshake outputs decode straight from state, so an async reset
    // removes bus_valid immediately rather than at the next edge.
    assign req_ready  = (state == S_IDLE);
    assign bus_valid  = (state == S_ADDR);
    assign resp_valid = (state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    // Illegal-size and misaligned ops answer directly without
                    // ever touching the bus.
                    state_nxt = (size_legal && !misalign) ? S_ADDR : S_RESP;
                end
            end
            S_ADDR: begin
                if (bus_ready) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bus_ack || timeout) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all datapath registers here are plain flops, not memories,
            // so each one gets an explicit reset value.
            bus_write     <= 1'b0;
            bus_addr      <= '0;
            bus_bsel      <= 8'h00;
            bus_wdata     <= 64'h0;
            resp_rdata    <= 64'h0;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
            timer         <= '0;
        end else begin
            // Timer runs only while waiting for an ack in S_DATA; it is zero
            // on every entry to S_DATA.
            if (state == S_DATA && !bus_ack && !timeout) begin
                timer <= timer + TMR_W'(1);
            end else begin
                timer <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        bus_write <= req_write;
                        bus_addr  <= {req_addr[PADDR_W-1:3], 3'b000};
                        bus_bsel  <= bsel_base << req_addr[2:0];
                        bus_wdata <= req_wdata;
                        // Response flags change only when this op's outcome
                        // is already known; bus ops update them in S_DATA.
                        if (!size_legal) begin
                            resp_err      <= 1'b1;
                            resp_misalign <= 1'b0;
                        end else if (misalign) begin
                            resp_err      <= 1'b0;
                            resp_misalign <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (bus_ack) begin
                        if (!bus_write) begin
                            resp_rdata <= bus_rdata;
                        end
                        resp_err      <= bus_err;
                        resp_misalign <= 1'b0;
                    end else if (timeout) begin
                        resp_err      <= 1'b1;
                        resp_misalign <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
